// File: rtl/neda_sample_player_pkg.sv
// Shared widths, FSM state encoding and small helpers for the sample player.
package neda_sample_player_pkg;

  localparam int DW    = 8;   // sample width, matches the NEDA datapath din
  localparam int DEPTH = 8;   // table entries
  localparam int AW    = 3;   // table address width
  localparam int CW    = 8;   // repeat-count width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Table index that follows cur within a frame of last+1 entries.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] cur,
                                              input logic [AW-1:0] last);
    return (cur == last) ? '0 : cur + AW'(1);
  endfunction

endpackage

// File: rtl/neda_sample_player_if.sv
// Control, table-load and sample-output bundle of the sample player.
interface neda_sample_player_if;
  import neda_sample_player_pkg::*;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          stop;
  logic [AW-1:0] last_idx;
  logic [CW-1:0] rpt;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          frame_sof;
  logic          busy;
  logic          done;

  // Player side
  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, last_idx, rpt,
    output dout, dout_vld, frame_sof, busy, done
  );

  // Controller side
  modport master (
    output wr_en, wr_addr, wr_data, start, stop, last_idx, rpt,
    input  dout, dout_vld, frame_sof, busy, done
  );

endinterface

// File: rtl/neda_sample_player_ram.sv
// Sample table: DEPTH x DW register file, synchronous write, asynchronous read.
// The read returns the pre-write contents during a same-address write cycle.
module neda_sample_player_ram
  import neda_sample_player_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Table write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/neda_sample_player.sv
// Sample player: streams table entries 0..last_idx onto dout once per clock,
// repeating the frame rpt times (or forever when rpt==0) until stopped.
module neda_sample_player
  import neda_sample_player_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  neda_sample_player_if.slave  bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;     // table index of the sample now on dout
  logic [CW-1:0] frm_q, frm_d;     // 1-based frame number of that sample
  logic [AW-1:0] last_q, last_d;
  logic [CW-1:0] rpt_q, rpt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          sof_q, sof_d;
  logic          done_q, done_d;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  neda_sample_player_ram u_ram (
    .clk       (clk),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Next-state, table read address and next output sample.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    frm_d   = frm_q;
    last_d  = last_q;
    rpt_d   = rpt_q;
    dout_d  = '0;
    vld_d   = 1'b0;
    sof_d   = 1'b0;
    done_d  = 1'b0;
    rd_addr = '0;
    case (state_q)
      ST_IDLE: begin
        // stop wins over a coincident start
        if (bus.start && !bus.stop) begin
          state_d = ST_PLAY;
          last_d  = bus.last_idx;
          rpt_d   = bus.rpt;
          cur_d   = '0;
          frm_d   = CW'(1);
          dout_d  = rd_data;
          vld_d   = 1'b1;
          sof_d   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (cur_q == last_q && rpt_q != '0 && frm_q == rpt_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          rd_addr = next_idx(cur_q, last_q);
          cur_d   = rd_addr;
          // frame number saturates so an endless run never aliases
          if (cur_q == last_q && frm_q != {CW{1'b1}}) frm_d = frm_q + CW'(1);
          dout_d  = rd_data;
          vld_d   = 1'b1;
          sof_d   = (rd_addr == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; all cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      frm_q   <= '0;
      last_q  <= '0;
      rpt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      frm_q   <= frm_d;
      last_q  <= last_d;
      rpt_q   <= rpt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.frame_sof = sof_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == ST_PLAY);

endmodule

// File: tb/tb_neda_sample_player.sv
// Bench for neda_sample_player: a stream-position model (samples emitted so
// far, frame length, repeat count) predicts every output each cycle; directed
// scenarios add literal checks, then a randomized phase exercises the rest.
module tb_neda_sample_player;
  import neda_sample_player_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neda_sample_player_if bus();

  neda_sample_player dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Playback is a stream position n; sample n is table[n % L], frame start
  // when n % L == 0, and a finite run ends once n reaches R*L samples.
  int          m_mode;   // 0 idle, 1 playing, 2 done
  int          m_L, m_R, m_n;
  logic [7:0]  m_tab [8];
  logic [7:0]  e_dout;
  logic        e_vld, e_sof, e_done, e_busy;

  initial begin
    m_mode = 0; m_L = 1; m_R = 0; m_n = 0;
    e_dout = '0; e_vld = 0; e_sof = 0; e_done = 0; e_busy = 0;
    for (int i = 0; i < 8; i++) m_tab[i] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      e_dout = '0; e_vld = 0; e_sof = 0; e_done = 0;
    end else begin
      e_dout = '0; e_vld = 0; e_sof = 0; e_done = 0;
      if (m_mode == 0) begin
        if (bus.start && !bus.stop) begin
          m_mode = 1;
          m_L = int'(bus.last_idx) + 1;
          m_R = int'(bus.rpt);
          m_n = 1;
          e_dout = m_tab[0]; e_vld = 1; e_sof = 1;
        end
      end else if (m_mode == 1) begin
        if (bus.stop) m_mode = 0;
        else if (m_R != 0 && m_n == m_R * m_L) begin
          m_mode = 2; e_done = 1;
        end else begin
          e_dout = m_tab[m_n % m_L];
          e_vld  = 1;
          e_sof  = ((m_n % m_L) == 0);
          m_n++;
        end
      end else begin
        m_mode = 0;
      end
      if (bus.wr_en) m_tab[bus.wr_addr] = bus.wr_data;
    end
    e_busy = (m_mode == 1);
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout",      32'(bus.dout),      32'(e_dout));
      chk("dout_vld",  32'(bus.dout_vld),  32'(e_vld));
      chk("frame_sof", 32'(bus.frame_sof), 32'(e_sof));
      chk("done",      32'(bus.done),      32'(e_done));
      chk("busy",      32'(bus.busy),      32'(e_busy));
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 0; bus.stop = 0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pulse start; returns at the negedge where the first sample is on dout.
  task automatic do_start(input logic [AW-1:0] last, input logic [CW-1:0] r);
    @(negedge clk);
    bus.last_idx = last; bus.rpt = r; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    bus.last_idx = $urandom_range(0, 7); bus.rpt = CW'($urandom_range(0, 255));
  endtask

  logic [7:0] ref1 [8];

  initial begin
    ref1[0] = 10; ref1[1] = 2;  ref1[2] = 8;  ref1[3] = 2;
    ref1[4] = 52; ref1[5] = 21; ref1[6] = 25; ref1[7] = 1;
    idle_inputs();
    bus.last_idx = '0; bus.rpt = '0;
    rst_n = 0;
    wait_neg(3);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_vld",  32'(bus.dout_vld), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst_n = 1;
    chk_en = 1;

    // Load the table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wr_en = 1; bus.wr_addr = AW'(i); bus.wr_data = ref1[i];
    end
    @(negedge clk);
    bus.wr_en = 0;

    // 1: one full frame, then done, then idle
    do_start(3'd7, 8'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_dout", 32'(bus.dout), 32'(ref1[i]));
      chk("t1_sof",  32'(bus.frame_sof), (i == 0) ? 1 : 0);
      @(negedge clk);
    end
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_vld0", 32'(bus.dout_vld), 0);
    @(negedge clk);
    chk("t1_idle", 32'(bus.busy), 0);
    chk("t1_done_1cyc", 32'(bus.done), 0);

    // 2: endless play, stop after 20 samples
    do_start(3'd7, 8'd0);
    wait_neg(19);
    chk("t2_sample20", 32'(bus.dout), 32'(ref1[3]));
    bus.stop = 1;
    @(negedge clk);
    bus.stop = 0;
    chk("t2_stop_vld",  32'(bus.dout_vld), 0);
    chk("t2_stop_done", 32'(bus.done), 0);
    chk("t2_stop_busy", 32'(bus.busy), 0);
    wait_neg(2);

    // 3: short frames
    do_start(3'd2, 8'd3);
    wait_neg(8);
    chk("t3_last", 32'(bus.dout), 8);
    @(negedge clk);
    chk("t3_done", 32'(bus.done), 1);
    wait_neg(2);
    do_start(3'd0, 8'd2);
    chk("t3b_s0", 32'(bus.dout), 10);
    @(negedge clk);
    chk("t3b_s1", 32'(bus.dout), 10);
    chk("t3b_sof", 32'(bus.frame_sof), 1);
    @(negedge clk);
    chk("t3b_done", 32'(bus.done), 1);
    wait_neg(2);

    // 4: start+stop together in idle, then start re-pulsed mid-play
    @(negedge clk);
    bus.start = 1; bus.stop = 1; bus.last_idx = 3'd7; bus.rpt = 8'd1;
    @(negedge clk);
    bus.start = 0; bus.stop = 0;
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_vld",  32'(bus.dout_vld), 0);
    do_start(3'd7, 8'd1);
    wait_neg(2);
    bus.start = 1; bus.last_idx = 3'd1; bus.rpt = 8'd5;
    @(negedge clk);
    bus.start = 0;
    chk("t4_unaffected", 32'(bus.dout), 32'(ref1[3]));
    wait_neg(8);

    // 5: same-cycle write to the entry being read shows up one frame later
    do_start(3'd7, 8'd0);
    wait_neg(3);
    bus.wr_en = 1; bus.wr_addr = 3'd4; bus.wr_data = 8'd99;
    @(negedge clk);
    bus.wr_en = 0;
    chk("t5_cur_frame", 32'(bus.dout), 52);
    wait_neg(8);
    chk("t5_next_frame", 32'(bus.dout), 99);
    bus.stop = 1;
    @(negedge clk);
    bus.stop = 0;
    wait_neg(2);

    // Randomized phase
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 15) == 0);
      bus.stop     = ($urandom_range(0, 39) == 0);
      bus.last_idx = AW'($urandom_range(0, 7));
      bus.rpt      = CW'($urandom_range(0, 3));
      bus.wr_en    = ($urandom_range(0, 3) == 0);
      bus.wr_addr  = AW'($urandom_range(0, 7));
      bus.wr_data  = DW'($urandom_range(0, 255));
    end
    @(negedge clk);
    idle_inputs();
    bus.stop = 1;
    @(negedge clk);
    bus.stop = 0;
    wait_neg(2);

    // 6: async reset mid-frame, then a fresh start replays from entry 0
    do_start(3'd7, 8'd0);
    wait_neg(3);
    #2;
    rst_n = 0;
    #1;
    chk("t6_rst_dout", 32'(bus.dout), 0);
    chk("t6_rst_vld",  32'(bus.dout_vld), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1;
    bus.wr_en = 1; bus.wr_addr = 3'd0; bus.wr_data = 8'd77;
    @(negedge clk);
    bus.wr_en = 0;
    do_start(3'd7, 8'd1);
    chk("t6_replay0", 32'(bus.dout), 77);
    chk("t6_replay_sof", 32'(bus.frame_sof), 1);
    wait_neg(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
